// File: rtl/fixed_add_pipe.sv
// Two-operand fixed-point adder with valid/ready join, LATENCY-deep stallable pipeline and overflow counter.
// Optional build macro FIXED_ADD_SAT_EN selects saturating results instead of wrap-around.
module fixed_add_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A_vld,
  input  logic [WIDTH-1:0] A_dat,
  output logic             A_rdy,
  input  logic             B_vld,
  input  logic [WIDTH-1:0] B_dat,
  output logic             B_rdy,
  output logic             S_vld,
  output logic [WIDTH-1:0] S_dat,
  output logic             S_ovf,
  input  logic             S_rdy,
  output logic [CNT_W-1:0] ovf_cnt
);

  function automatic logic [WIDTH-1:0] fmt_res(input logic signed [WIDTH:0] sum);
`ifdef FIXED_ADD_SAT_EN
    if (sum[WIDTH] != sum[WIDTH-1])
      return sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return sum[WIDTH-1:0];
`else
    return sum[WIDTH-1:0];
`endif
  endfunction

  logic [LATENCY-1:0]            vld_q, vld_d;
  logic [LATENCY-1:0]            ovf_q, ovf_d;
  logic [LATENCY-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic                 stall, fire;
  logic signed [WIDTH:0] a_ext_p0, b_ext_p0, sum_p0;
  logic                 ovf_p0;

  assign stall = vld_q[LATENCY-1] && !S_rdy;
  assign fire  = A_vld && B_vld && !stall;
  assign A_rdy = B_vld && !stall;
  assign B_rdy = A_vld && !stall;

  // Stage 0 input: sign-extended sum, overflow when the two top bits disagree
  assign a_ext_p0 = {A_dat[WIDTH-1], A_dat};
  assign b_ext_p0 = {B_dat[WIDTH-1], B_dat};
  assign sum_p0   = a_ext_p0 + b_ext_p0;
  assign ovf_p0   = sum_p0[WIDTH] ^ sum_p0[WIDTH-1];

  always_comb begin
    vld_d = vld_q;
    ovf_d = ovf_q;
    dat_d = dat_q;
    cnt_d = cnt_q;
    if (!stall) begin
      vld_d[0] = fire;
      ovf_d[0] = ovf_p0;
      dat_d[0] = fmt_res(sum_p0);
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        ovf_d[i] = ovf_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
    if (fire && ovf_p0 && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Pipeline registers; reset clears data too so outputs are never X
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ovf_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign S_vld   = vld_q[LATENCY-1];
  assign S_ovf   = ovf_q[LATENCY-1];
  assign S_dat   = dat_q[LATENCY-1];
  assign ovf_cnt = cnt_q;

endmodule

// File: tb/tb_fixed_add_pipe.sv
// Directed bench for fixed_add_pipe at WIDTH=16, LATENCY=2; honours FIXED_ADD_SAT_EN for expected sums.
module tb_fixed_add_pipe;
  localparam int W = 16;
  localparam int L = 2;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         A_vld, B_vld, S_rdy;
  logic [W-1:0] A_dat, B_dat;
  logic         A_rdy, B_rdy, S_vld, S_ovf;
  logic [W-1:0] S_dat;
  logic [C-1:0] ovf_cnt;

  int n_chk = 0;
  int n_err = 0;

  fixed_add_pipe #(.WIDTH(W), .LATENCY(L), .CNT_W(C)) dut (
    .clk(clk), .rst(rst),
    .A_vld(A_vld), .A_dat(A_dat), .A_rdy(A_rdy),
    .B_vld(B_vld), .B_dat(B_dat), .B_rdy(B_rdy),
    .S_vld(S_vld), .S_dat(S_dat), .S_ovf(S_ovf), .S_rdy(S_rdy),
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated operation; inputs change on negedge, outputs sampled on negedge
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] exp_s, input logic exp_o, input int exp_cnt);
    A_dat = a; B_dat = b; A_vld = 1'b1; B_vld = 1'b1; S_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    A_vld = 1'b0; B_vld = 1'b0;
    chk({tag, "_early"}, S_vld, 1'b0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_vld"}, S_vld, 1'b1);
    chk({tag, "_dat"}, S_dat, exp_s);
    chk({tag, "_ovf"}, S_ovf, exp_o);
    chk({tag, "_cnt"}, ovf_cnt, exp_cnt);
    @(posedge clk); @(negedge clk);
    chk({tag, "_once"}, S_vld, 1'b0);
  endtask

  // Ten pairs (i, 2i), i=1..10; mode 1 toggles S_rdy 1,0,0,1
  task automatic stream(input string tag, input int mode);
    int tx = 0, rx = 0, cyc = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] held = '0;
    while (rx < 10) begin
      S_rdy = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      A_vld = (tx < 10); B_vld = (tx < 10);
      A_dat = W'(tx + 1); B_dat = W'(2 * (tx + 1));
      #1;
      if (prev_stall) chk({tag, "_hold"}, S_dat, held);
      prev_stall = S_vld && !S_rdy;
      if (prev_stall) begin
        chk({tag, "_ardy_stall"}, A_rdy, 1'b0);
        chk({tag, "_brdy_stall"}, B_rdy, 1'b0);
        held = S_dat;
      end
      if (mode == 0 && rx > 0) chk({tag, "_gap"}, S_vld, 1'b1);
      if (S_vld && S_rdy) begin
        chk({tag, "_dat"}, S_dat, W'(3 * (rx + 1)));
        rx++;
      end
      if (A_vld && A_rdy) tx++;
      cyc++;
      if (cyc > 200) begin
        chk({tag, "_timeout"}, rx, 10);
        break;
      end
      @(posedge clk); @(negedge clk);
    end
    A_vld = 1'b0; B_vld = 1'b0; S_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk({tag, "_nodup"}, S_vld, 1'b0);
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1; A_vld = 1'b1; B_vld = 1'b1; S_rdy = 1'b0;
    A_dat = 16'h1111; B_dat = 16'h2222;
    @(posedge clk); @(negedge clk);
    chk("rst_svld", S_vld, 1'b0);
    chk("rst_sdat", S_dat, 16'h0000);
    chk("rst_sovf", S_ovf, 1'b0);
    chk("rst_cnt", ovf_cnt, 0);
    chk("rst_ardy", A_rdy, 1'b1);
    chk("rst_brdy", B_rdy, 1'b1);
    @(posedge clk); @(negedge clk);
    A_vld = 1'b0; B_vld = 1'b0;
    rst = 1'b0;

    op("add_3_4", 16'h0003, 16'h0004, 16'h0007, 1'b0, 0);
`ifdef FIXED_ADD_SAT_EN
    op("pos_ovf", 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1);
    op("neg_ovf", 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 2);
    op("min_min", 16'h8000, 16'h8000, 16'h8000, 1'b1, 3);
`else
    op("pos_ovf", 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1);
    op("neg_ovf", 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 2);
    op("min_min", 16'h8000, 16'h8000, 16'h0000, 1'b1, 3);
`endif
    op("m1_p1", 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 3);

    stream("str", 0);
    stream("bp", 1);

    // One-sided valid: A waits until B shows up
    S_rdy = 1'b1; A_vld = 1'b1; A_dat = 16'd5; B_vld = 1'b0; B_dat = 16'd6;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("one_ardy", A_rdy, 1'b0);
      chk("one_svld", S_vld, 1'b0);
      @(posedge clk); @(negedge clk);
    end
    B_vld = 1'b1;
    #1 chk("one_ardy_join", A_rdy, 1'b1);
    @(posedge clk); @(negedge clk);
    A_vld = 1'b0; B_vld = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (S_vld) begin
        seen++;
        chk("one_dat", S_dat, 16'd11);
      end
      @(posedge clk); @(negedge clk);
    end
    chk("one_count", seen, 1);

    // Reset with two results parked behind S_rdy=0
    S_rdy = 1'b0; A_vld = 1'b1; B_vld = 1'b1; A_dat = 16'd1; B_dat = 16'd1;
    @(posedge clk); @(negedge clk);
    A_dat = 16'd2; B_dat = 16'd2;
    @(posedge clk); @(negedge clk);
    A_vld = 1'b0; B_vld = 1'b0;
    chk("fl_svld", S_vld, 1'b1);
    chk("fl_cnt_before", ovf_cnt, 3);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("fl_rst_svld", S_vld, 1'b0);
    chk("fl_rst_cnt", ovf_cnt, 0);
    S_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("fl_gone", S_vld, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
